chunk_row_sequencer: RTL and testbench

- Row-level scheduler in front of the ChunkRow command generator inside ChunkAddrLooper.
- Accepts one 2D block descriptor and emits one row descriptor per row on a rdy/ack interface, for direct connection to ChunkRow's row port.
- Each row descriptor carries: linear row start address, row-valid flag (vertical bounds), per-row pad length, and last-row flag.

---
 rtl/chunk_row_sequencer.sv | 146 ++++++++++++++
 tb/tb_chunk_row_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunk_row_sequencer.sv
// ---------------------------------------------------------------------------
// chunk_row_sequencer
//
// Row-level scheduler that sits in front of the ChunkRow command generator.
// It accepts one 2D block descriptor and produces one row descriptor per row
// on a rdy/ack interface. Each row descriptor carries:
//   - the linear start address of the row,
//   - a flag saying whether the row index lies in the vertical window,
//   - the pad length, which is the same for every row of the block,
//   - a flag marking the final row of the final block of a tile.
//
// Ports
//   i_clk, i_rst    clock; synchronous active-high reset
//   blk_rdy/blk_ack block descriptor handshake (blk_ack high whenever idle)
//   i_blk_base      linear address of row 0
//   i_blk_stride    address increment per row (two's complement)
//   i_blk_nrow      number of rows; a value of 0 is an empty block
//   i_blk_vbeg      signed first valid row index
//   i_blk_vend      signed exclusive end of the valid rows
//   i_blk_pad       pad length, copied to every row
//   i_blk_islast    block is the last one of the tile
//   row_rdy/row_ack row descriptor handshake
//   o_row_linear    row start address
//   o_row_islast    last row of a last block
//   o_row_pad       pad length
//   o_row_valid     row index lies inside [vbeg, vend)
// ---------------------------------------------------------------------------
module chunk_row_sequencer #(
  parameter int GBW     = 32,
  parameter int VSIZE   = 32,
  parameter int RCNT_BW = 16,
  localparam int V_BW   = $clog2(VSIZE)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  // block descriptor port
  input  logic                      blk_rdy,
  output logic                      blk_ack,
  input  logic [GBW-1:0]            i_blk_base,
  input  logic [GBW-1:0]            i_blk_stride,
  input  logic [RCNT_BW-1:0]        i_blk_nrow,
  input  logic signed [RCNT_BW:0]   i_blk_vbeg,
  input  logic signed [RCNT_BW:0]   i_blk_vend,
  input  logic [V_BW-1:0]           i_blk_pad,
  input  logic                      i_blk_islast,
  // row descriptor port
  output logic                      row_rdy,
  input  logic                      row_ack,
  output logic [GBW-1:0]            o_row_linear,
  output logic                      o_row_islast,
  output logic [V_BW-1:0]           o_row_pad,
  output logic                      o_row_valid
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [RCNT_BW-1:0] ONE = RCNT_BW'(1);

  state_t                    state;
  logic                      row_rdy_r;
  logic [GBW-1:0]            addr_r;
  logic [GBW-1:0]            stride_r;
  logic [RCNT_BW-1:0]        idx_r;
  logic [RCNT_BW-1:0]        nrow_r;
  logic signed [RCNT_BW:0]   vbeg_r;
  logic signed [RCNT_BW:0]   vend_r;
  logic [V_BW-1:0]           pad_r;
  logic                      islast_r;

  // Row index widened with a zero sign bit so it compares correctly against
  // the signed window bounds, which may be negative.
  logic signed [RCNT_BW:0]   idx_s;
  logic                      last_row;

  assign idx_s    = $signed({1'b0, idx_r});
  // nrow_r is never zero while in RUN, so nrow_r - 1 cannot wrap there.
  assign last_row = (idx_r == nrow_r - ONE);

  // Only the handshake with the block source is decoded from the state; all
  // row outputs come straight from registers or from logic on registers, so
  // they stay stable for as long as the consumer withholds row_ack.
  assign blk_ack      = (state == IDLE);
  assign row_rdy      = row_rdy_r;
  assign o_row_linear = addr_r;
  assign o_row_pad    = pad_r;
  assign o_row_valid  = (idx_s >= vbeg_r) && (idx_s < vend_r);
  assign o_row_islast = islast_r && last_row;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours regardless of
  // statement order within the block.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      row_rdy_r <= 1'b0;
      addr_r    <= '0;
      stride_r  <= '0;
      idx_r     <= '0;
      nrow_r    <= '0;
      vbeg_r    <= '0;
      vend_r    <= '0;
      pad_r     <= '0;
      islast_r  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // An empty block is acknowledged but leaves every register alone.
          if (blk_rdy && (i_blk_nrow != '0)) begin
            state     <= RUN;
            row_rdy_r <= 1'b1;
            addr_r    <= i_blk_base;
            stride_r  <= i_blk_stride;
            idx_r     <= '0;
            nrow_r    <= i_blk_nrow;
            vbeg_r    <= i_blk_vbeg;
            vend_r    <= i_blk_vend;
            pad_r     <= i_blk_pad;
            islast_r  <= i_blk_islast;
          end
        end
        RUN: begin
          if (row_ack) begin
            if (last_row) begin
              // Returning to IDLE costs one bubble cycle before the next
              // block can be accepted.
              state     <= IDLE;
              row_rdy_r <= 1'b0;
            end else begin
              // Address arithmetic wraps silently modulo 2^GBW.
              addr_r <= addr_r + stride_r;
              idx_r  <= idx_r + ONE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          row_rdy_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_row_sequencer.sv
// ---------------------------------------------------------------------------
// tb_chunk_row_sequencer
//
// Self-checking bench for chunk_row_sequencer: a directed per-cycle vector
// table, hand-written backpressure and reset sequences, and a randomized run
// checked against a row-list reference model.
// ---------------------------------------------------------------------------
module tb_chunk_row_sequencer;

  localparam int GBW     = 32;
  localparam int VSIZE   = 32;
  localparam int RCNT_BW = 16;
  localparam int V_BW    = $clog2(VSIZE);

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 blk_rdy;
  logic                 blk_ack;
  logic [GBW-1:0]       i_blk_base;
  logic [GBW-1:0]       i_blk_stride;
  logic [RCNT_BW-1:0]   i_blk_nrow;
  logic [RCNT_BW:0]     i_blk_vbeg;
  logic [RCNT_BW:0]     i_blk_vend;
  logic [V_BW-1:0]      i_blk_pad;
  logic                 i_blk_islast;
  logic                 row_rdy;
  logic                 row_ack;
  logic [GBW-1:0]       o_row_linear;
  logic                 o_row_islast;
  logic [V_BW-1:0]      o_row_pad;
  logic                 o_row_valid;

  int n_checks = 0;
  int n_errors = 0;

  chunk_row_sequencer #(
    .GBW     (GBW),
    .VSIZE   (VSIZE),
    .RCNT_BW (RCNT_BW)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .blk_rdy      (blk_rdy),
    .blk_ack      (blk_ack),
    .i_blk_base   (i_blk_base),
    .i_blk_stride (i_blk_stride),
    .i_blk_nrow   (i_blk_nrow),
    .i_blk_vbeg   (i_blk_vbeg),
    .i_blk_vend   (i_blk_vend),
    .i_blk_pad    (i_blk_pad),
    .i_blk_islast (i_blk_islast),
    .row_rdy      (row_rdy),
    .row_ack      (row_ack),
    .o_row_linear (o_row_linear),
    .o_row_islast (o_row_islast),
    .o_row_pad    (o_row_pad),
    .o_row_valid  (o_row_valid)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_blk(input bit rdy, input logic [31:0] base, input logic [31:0] stride,
                           input int nrow, input int vb, input int ve,
                           input int pad, input bit isl);
    blk_rdy      = rdy;
    i_blk_base   = base;
    i_blk_stride = stride;
    i_blk_nrow   = RCNT_BW'(nrow);
    i_blk_vbeg   = (RCNT_BW+1)'(vb);
    i_blk_vend   = (RCNT_BW+1)'(ve);
    i_blk_pad    = V_BW'(pad);
    i_blk_islast = isl;
  endtask

  // ---------------- directed per-cycle vector table -------------------------
  typedef struct {
    bit          blk_rdy;
    logic [31:0] base;
    logic [31:0] stride;
    int          nrow;
    int          vbeg;
    int          vend;
    int          pad;
    bit          islast;
    bit          e_blk_ack;
    bit          e_row_rdy;
    logic [31:0] e_linear;
    bit          e_valid;
    bit          e_islast;
    int          e_pad;
  } vec_t;

  vec_t vecs[$];

  // Idle cycle that offers a block; the sequencer is expected to be idle.
  function automatic vec_t v_blk(logic [31:0] base, logic [31:0] stride, int nrow,
                                 int vb, int ve, int pad, bit isl);
    vec_t v;
    v = '{blk_rdy: 1'b1, base: base, stride: stride, nrow: nrow, vbeg: vb, vend: ve,
          pad: pad, islast: isl, e_blk_ack: 1'b1, e_row_rdy: 1'b0, e_linear: '0,
          e_valid: 1'b0, e_islast: 1'b0, e_pad: 0};
    return v;
  endfunction

  // Cycle presenting a row that is acknowledged at once.
  function automatic vec_t v_row(logic [31:0] lin, bit val, bit isl, int pad);
    vec_t v;
    v = '{blk_rdy: 1'b0, base: '0, stride: '0, nrow: 0, vbeg: 0, vend: 0,
          pad: 0, islast: 1'b0, e_blk_ack: 1'b0, e_row_rdy: 1'b1, e_linear: lin,
          e_valid: val, e_islast: isl, e_pad: pad};
    return v;
  endfunction

  function automatic vec_t v_idle();
    vec_t v;
    v = v_blk('0, '0, 0, 0, 0, 0, 1'b0);
    v.blk_rdy = 1'b0;
    return v;
  endfunction

  // ---------------- reference model for the randomized run ------------------
  typedef struct {
    logic [31:0] lin;
    bit          val;
    bit          isl;
    logic [4:0]  pad;
  } row_t;

  row_t exp_q[$];

  // Expands a block into its list of rows straight from the definition:
  // row k starts at base + k*stride and is valid when vbeg <= k < vend.
  task automatic model_block(input logic [31:0] base, input logic [31:0] stride,
                             input int nrow, input int vb, input int ve,
                             input int pad, input bit isl);
    for (int k = 0; k < nrow; k++) begin
      row_t r;
      r.lin = base + stride * 32'(k);
      r.val = (k >= vb) && (k < ve);
      r.isl = isl && (k == nrow - 1);
      r.pad = 5'(pad);
      exp_q.push_back(r);
    end
  endtask

  initial begin
    int xfers;

    i_rst   = 1'b1;
    row_ack = 1'b0;
    drive_blk(1'b0, '0, '0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(negedge i_clk);

    // Reset state
    check("rst_blk_ack", blk_ack, 1);
    check("rst_row_rdy", row_rdy, 0);
    check("rst_linear", o_row_linear, 0);
    check("rst_pad", o_row_pad, 0);
    check("rst_valid", o_row_valid, 0);
    check("rst_islast", o_row_islast, 0);
    i_rst = 1'b0;

    // Basic block, vertical window, negative stride with wrap, empty block,
    // pad copy with an empty (vbeg >= vend) window.
    vecs.push_back(v_blk(32'h1000, 32'h100, 3, 0, 3, 0, 1'b1));
    vecs.push_back(v_row(32'h1000, 1, 0, 0));
    vecs.push_back(v_row(32'h1100, 1, 0, 0));
    vecs.push_back(v_row(32'h1200, 1, 1, 0));
    vecs.push_back(v_blk(32'h2000, 32'd64, 4, 1, 3, 3, 1'b0));
    vecs.push_back(v_row(32'h2000, 0, 0, 3));
    vecs.push_back(v_row(32'h2040, 1, 0, 3));
    vecs.push_back(v_row(32'h2080, 1, 0, 3));
    vecs.push_back(v_row(32'h20C0, 0, 0, 3));
    vecs.push_back(v_blk(32'h40, 32'hFFFF_FFC0, 3, -1, 2, 31, 1'b1));
    vecs.push_back(v_row(32'h40, 1, 0, 31));
    vecs.push_back(v_row(32'h0, 1, 0, 31));
    vecs.push_back(v_row(32'hFFFF_FFC0, 0, 1, 31));
    vecs.push_back(v_blk(32'hDEAD, 32'h4, 0, 0, 5, 7, 1'b1));
    vecs.push_back(v_blk(32'h5555, 32'h7, 1, 5, 2, 5, 1'b1));
    vecs.push_back(v_row(32'h5555, 0, 1, 5));
    vecs.push_back(v_idle());
    vecs.push_back(v_idle());

    row_ack = 1'b1;
    foreach (vecs[i]) begin
      @(negedge i_clk);
      check($sformatf("vec%0d_blk_ack", i), blk_ack, vecs[i].e_blk_ack);
      check($sformatf("vec%0d_row_rdy", i), row_rdy, vecs[i].e_row_rdy);
      if (vecs[i].e_row_rdy) begin
        check($sformatf("vec%0d_linear", i), o_row_linear, vecs[i].e_linear);
        check($sformatf("vec%0d_valid", i), o_row_valid, vecs[i].e_valid);
        check($sformatf("vec%0d_islast", i), o_row_islast, vecs[i].e_islast);
        check($sformatf("vec%0d_pad", i), o_row_pad, vecs[i].e_pad);
      end
      drive_blk(vecs[i].blk_rdy, vecs[i].base, vecs[i].stride, vecs[i].nrow,
                vecs[i].vbeg, vecs[i].vend, vecs[i].pad, vecs[i].islast);
    end

    // Backpressure: row 0 must hold through five stalled cycles.
    @(negedge i_clk);
    row_ack = 1'b0;
    drive_blk(1'b1, 32'h3000, 32'h10, 2, 0, 2, 1, 1'b1);
    for (int s = 0; s < 5; s++) begin
      @(negedge i_clk);
      blk_rdy = 1'b0;
      check($sformatf("stall%0d_row_rdy", s), row_rdy, 1);
      check($sformatf("stall%0d_linear", s), o_row_linear, 32'h3000);
      check($sformatf("stall%0d_islast", s), o_row_islast, 0);
      check($sformatf("stall%0d_valid", s), o_row_valid, 1);
      check($sformatf("stall%0d_pad", s), o_row_pad, 1);
    end
    xfers = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge i_clk);
      if (row_rdy) begin
        check($sformatf("bp_xfer%0d_linear", xfers), o_row_linear, 32'h3000 + 32'h10 * 32'(xfers));
        check($sformatf("bp_xfer%0d_islast", xfers), o_row_islast, (xfers == 1));
        xfers++;
        row_ack = 1'b1;
      end
    end
    check("bp_transfer_count", xfers, 2);

    // Reset in the middle of a block.
    @(negedge i_clk);
    row_ack = 1'b1;
    drive_blk(1'b1, 32'h7000, 32'h20, 10, 0, 10, 0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      blk_rdy = 1'b0;
      check($sformatf("mid%0d_row_rdy", k), row_rdy, 1);
      check($sformatf("mid%0d_linear", k), o_row_linear, 32'h7000 + 32'h20 * 32'(k));
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    check("midrst_row_rdy", row_rdy, 0);
    check("midrst_blk_ack", blk_ack, 1);
    i_rst = 1'b0;
    drive_blk(1'b1, 32'hA000, 32'h4, 2, 0, 1, 2, 1'b0);
    @(negedge i_clk);
    blk_rdy = 1'b0;
    check("post_rst_row_rdy", row_rdy, 1);
    check("post_rst_linear0", o_row_linear, 32'hA000);
    check("post_rst_valid0", o_row_valid, 1);
    check("post_rst_islast0", o_row_islast, 0);
    check("post_rst_pad0", o_row_pad, 2);
    @(negedge i_clk);
    check("post_rst_linear1", o_row_linear, 32'hA004);
    check("post_rst_valid1", o_row_valid, 0);
    @(negedge i_clk);
    check("post_rst_idle", blk_ack, 1);

    // Randomized run against the row-list model.
    exp_q.delete();
    for (int c = 0; c < 4000; c++) begin
      bit br, ra;
      logic [31:0] base, stride;
      int nrow, vb, ve, pad;
      bit isl;
      @(negedge i_clk);
      check("rnd_blk_ack", blk_ack, (exp_q.size() == 0));
      check("rnd_row_rdy", row_rdy, (exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("rnd_linear", o_row_linear, exp_q[0].lin);
        check("rnd_valid", o_row_valid, exp_q[0].val);
        check("rnd_islast", o_row_islast, exp_q[0].isl);
        check("rnd_pad", o_row_pad, exp_q[0].pad);
      end
      br     = ($urandom_range(0, 3) != 0);
      ra     = (c < 3950) ? ($urandom_range(0, 2) != 0) : 1'b1;
      base   = $urandom;
      stride = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
      nrow   = $urandom_range(0, 6);
      vb     = int'($urandom_range(0, 10)) - 3;
      ve     = int'($urandom_range(0, 10)) - 3;
      pad    = $urandom_range(0, 31);
      isl    = $urandom_range(0, 1);
      if (c >= 3950) br = 1'b0;
      drive_blk(br, base, stride, nrow, vb, ve, pad, isl);
      row_ack = ra;
      if (exp_q.size() != 0) begin
        if (ra) void'(exp_q.pop_front());
      end else if (br && nrow != 0) begin
        model_block(base, stride, nrow, vb, ve, pad, isl);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
